// File: rtl/param_stack_if.sv
// Command/status bundle for param_stack: the CPU side drives ops, the stack returns top-of-stack views and status.
interface param_stack_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             stack_enable;
    logic [2:0]       stack_op;
    logic [WIDTH-1:0] push_value;
    logic             err_clear;
    logic [WIDTH-1:0] popped_high;
    logic [WIDTH-1:0] popped_low;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;
    logic [CW-1:0]    high_water;

    modport master (
        output stack_enable, stack_op, push_value, err_clear,
        input  popped_high, popped_low, count, full, empty,
               overflow, underflow, high_water
    );

    modport slave (
        input  stack_enable, stack_op, push_value, err_clear,
        output popped_high, popped_low, count, full, empty,
               overflow, underflow, high_water
    );
endinterface

// File: rtl/param_stack.sv
// Parameterised LIFO with PUSH/REPLACE/POP2/BINOP/POP/DUP/SWAP; one-edge update, combinational top-two reads.
// No backpressure: illegal ops are suppressed and latched into sticky overflow/underflow flags.
module param_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input logic      clock,
    input logic      reset,
    param_stack_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [CW-1:0]    cnt_t;
    typedef logic [AW-1:0]    idx_t;
    typedef logic [WIDTH-1:0] dat_t;

    typedef enum logic [2:0] {
        OP_PUSH    = 3'd0,
        OP_REPLACE = 3'd1,
        OP_POP2    = 3'd2,
        OP_BINOP   = 3'd3,
        OP_POP     = 3'd4,
        OP_DUP     = 3'd5,
        OP_SWAP    = 3'd6,
        OP_NOP     = 3'd7
    } op_e;

    dat_t mem [DEPTH];

    cnt_t count_q;
    cnt_t high_water_q;
    logic overflow_q;
    logic underflow_q;

    idx_t idx_n;
    idx_t idx_m1;
    idx_t idx_m2;
    dat_t rd_top;
    dat_t rd_below;

    assign idx_n    = idx_t'(count_q);
    assign idx_m1   = idx_t'(count_q - cnt_t'(1));
    assign idx_m2   = idx_t'(count_q - cnt_t'(2));
    assign rd_top   = mem[idx_m1];
    assign rd_below = mem[idx_m2];

    cnt_t need_min;
    logic need_space;
    cnt_t count_after;
    logic wa_en;
    idx_t wa_idx;
    dat_t wa_dat;
    logic wb_en;
    idx_t wb_idx;
    dat_t wb_dat;

    // Per-op requirements and write ports, assuming the op is legal.
    always_comb begin
        need_min    = '0;
        need_space  = 1'b0;
        count_after = count_q;
        wa_en       = 1'b0;
        wa_idx      = idx_n;
        wa_dat      = bus.push_value;
        wb_en       = 1'b0;
        wb_idx      = idx_m2;
        wb_dat      = rd_top;
        case (op_e'(bus.stack_op))
            OP_PUSH: begin
                need_space  = 1'b1;
                count_after = count_q + cnt_t'(1);
                wa_en       = 1'b1;
                wa_idx      = idx_n;
            end
            OP_REPLACE: begin
                need_min = cnt_t'(1);
                wa_en    = 1'b1;
                wa_idx   = idx_m1;
            end
            OP_POP2: begin
                need_min    = cnt_t'(2);
                count_after = count_q - cnt_t'(2);
            end
            OP_BINOP: begin
                need_min    = cnt_t'(2);
                count_after = count_q - cnt_t'(1);
                wa_en       = 1'b1;
                wa_idx      = idx_m2;
            end
            OP_POP: begin
                need_min    = cnt_t'(1);
                count_after = count_q - cnt_t'(1);
            end
            OP_DUP: begin
                need_min    = cnt_t'(1);
                need_space  = 1'b1;
                count_after = count_q + cnt_t'(1);
                wa_en       = 1'b1;
                wa_idx      = idx_n;
                wa_dat      = rd_top;
            end
            OP_SWAP: begin
                need_min = cnt_t'(2);
                wa_en    = 1'b1;
                wa_idx   = idx_m1;
                wa_dat   = rd_below;
                wb_en    = 1'b1;
                wb_idx   = idx_m2;
                wb_dat   = rd_top;
            end
            default: begin
                need_min = '0;
            end
        endcase
    end

    logic uf_viol;
    logic of_viol;
    logic commit;
    cnt_t count_d;
    cnt_t high_water_d;

    // Underflow is checked first so DUP on an empty stack reports only underflow.
    assign uf_viol      = bus.stack_enable && (count_q < need_min);
    assign of_viol      = bus.stack_enable && !uf_viol && need_space && (count_q == cnt_t'(DEPTH));
    assign commit       = bus.stack_enable && !uf_viol && !of_viol;
    assign count_d      = commit ? count_after : count_q;
    assign high_water_d = (count_d > high_water_q) ? count_d : high_water_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q      <= '0;
            high_water_q <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            count_q      <= count_d;
            high_water_q <= high_water_d;
            overflow_q   <= (overflow_q && !bus.err_clear) || of_viol;
            underflow_q  <= (underflow_q && !bus.err_clear) || uf_viol;
        end
    end

    // Storage is not reset; writes are blocked while reset is held so no op leaks through.
    always_ff @(posedge clock) begin
        if (reset && commit && wa_en) begin
            mem[wa_idx] <= wa_dat;
        end
        if (reset && commit && wb_en) begin
            mem[wb_idx] <= wb_dat;
        end
    end

    assign bus.popped_high = (count_q >= cnt_t'(1)) ? rd_top : '0;
    assign bus.popped_low  = (count_q >= cnt_t'(2)) ? rd_below : '0;
    assign bus.count       = count_q;
    assign bus.full        = (count_q == cnt_t'(DEPTH));
    assign bus.empty       = (count_q == '0);
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
    assign bus.high_water  = high_water_q;
endmodule

// File: tb/tb_param_stack.sv
// Directed bench: an 8x4 stack through push/pop/error/reset cases, then a 12x8 stack filled to full.
module tb_param_stack;
    localparam logic [2:0] PUSH = 3'd0, REPLACE = 3'd1, POP2 = 3'd2, BINOP = 3'd3,
                           POP = 3'd4, DUP = 3'd5, SWAP = 3'd6, NOP = 3'd7;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    param_stack_if #(.WIDTH(8),  .DEPTH(4)) bus_a ();
    param_stack_if #(.WIDTH(12), .DEPTH(8)) bus_b ();

    param_stack #(.WIDTH(8),  .DEPTH(4)) dut_a (.clock(clock), .reset(reset), .bus(bus_a.slave));
    param_stack #(.WIDTH(12), .DEPTH(8)) dut_b (.clock(clock), .reset(reset), .bus(bus_b.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step_a(input logic en, input logic [2:0] op, input logic [7:0] val, input logic clr);
        @(negedge clock);
        bus_a.stack_enable = en;
        bus_a.stack_op     = op;
        bus_a.push_value   = val;
        bus_a.err_clear    = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic step_b(input logic en, input logic [2:0] op, input logic [11:0] val);
        @(negedge clock);
        bus_b.stack_enable = en;
        bus_b.stack_op     = op;
        bus_b.push_value   = val;
        bus_b.err_clear    = 1'b0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        bus_a.stack_enable = 1'b0; bus_a.stack_op = NOP; bus_a.push_value = '0; bus_a.err_clear = 1'b0;
        bus_b.stack_enable = 1'b0; bus_b.stack_op = NOP; bus_b.push_value = '0; bus_b.err_clear = 1'b0;

        // Reset state, and ops presented during reset are ignored
        #3;
        chk("rst_count", 32'(bus_a.count), 0);
        chk("rst_empty", 32'(bus_a.empty), 1);
        chk("rst_full", 32'(bus_a.full), 0);
        chk("rst_high", 32'(bus_a.popped_high), 0);
        chk("rst_low", 32'(bus_a.popped_low), 0);
        chk("rst_flags", {30'd0, bus_a.overflow, bus_a.underflow}, 0);
        chk("rst_hw", 32'(bus_a.high_water), 0);
        step_a(1'b1, PUSH, 8'h5A, 1'b0);
        chk("rst_op_ignored", 32'(bus_a.count), 0);
        @(negedge clock);
        reset = 1'b1;
        bus_a.stack_enable = 1'b0;

        // 1: three pushes
        step_a(1'b1, PUSH, 8'h11, 1'b0);
        step_a(1'b1, PUSH, 8'h22, 1'b0);
        step_a(1'b1, PUSH, 8'h33, 1'b0);
        chk("c1_count", 32'(bus_a.count), 3);
        chk("c1_high", 32'(bus_a.popped_high), 32'h33);
        chk("c1_low", 32'(bus_a.popped_low), 32'h22);
        chk("c1_hw", 32'(bus_a.high_water), 3);
        chk("c1_empty_full", {30'd0, bus_a.empty, bus_a.full}, 0);

        // 2: fill, overflow on PUSH and DUP
        step_a(1'b1, PUSH, 8'h44, 1'b0);
        chk("c2_full", 32'(bus_a.full), 1);
        step_a(1'b1, PUSH, 8'h55, 1'b0);
        chk("c2_ovf", 32'(bus_a.overflow), 1);
        chk("c2_count", 32'(bus_a.count), 4);
        chk("c2_high", 32'(bus_a.popped_high), 32'h44);
        step_a(1'b1, DUP, 8'h00, 1'b0);
        chk("c2_dup_flags", {30'd0, bus_a.overflow, bus_a.underflow}, 32'b10);
        chk("c2_dup_count", 32'(bus_a.count), 4);
        chk("c2_dup_low", 32'(bus_a.popped_low), 32'h33);

        // 3: BINOP, SWAP, POP2
        step_a(1'b1, BINOP, 8'h77, 1'b0);
        chk("c3_binop_count", 32'(bus_a.count), 3);
        chk("c3_binop_high", 32'(bus_a.popped_high), 32'h77);
        chk("c3_binop_low", 32'(bus_a.popped_low), 32'h22);
        step_a(1'b1, SWAP, 8'h00, 1'b0);
        chk("c3_swap_high", 32'(bus_a.popped_high), 32'h22);
        chk("c3_swap_low", 32'(bus_a.popped_low), 32'h77);
        step_a(1'b1, POP2, 8'h00, 1'b0);
        chk("c3_pop2_count", 32'(bus_a.count), 1);
        chk("c3_pop2_high", 32'(bus_a.popped_high), 32'h11);
        chk("c3_pop2_low", 32'(bus_a.popped_low), 0);
        chk("c3_ovf_sticky", 32'(bus_a.overflow), 1);

        // 4: underflow and err_clear interplay
        step_a(1'b1, POP2, 8'h00, 1'b0);
        chk("c4_unf", 32'(bus_a.underflow), 1);
        chk("c4_unf_count", 32'(bus_a.count), 1);
        step_a(1'b0, NOP, 8'h00, 1'b1);
        chk("c4_clear_flags", {30'd0, bus_a.overflow, bus_a.underflow}, 0);
        step_a(1'b1, SWAP, 8'h00, 1'b1);
        chk("c4_clear_and_viol", {30'd0, bus_a.overflow, bus_a.underflow}, 32'b01);
        chk("c4_swap_count", 32'(bus_a.count), 1);
        step_a(1'b0, NOP, 8'h00, 1'b1);

        // 5: DUP, REPLACE, drain
        step_a(1'b1, DUP, 8'h00, 1'b0);
        chk("c5_dup_count", 32'(bus_a.count), 2);
        chk("c5_dup_both", {16'd0, bus_a.popped_high, bus_a.popped_low}, 32'h1111);
        step_a(1'b1, REPLACE, 8'h99, 1'b0);
        chk("c5_repl_both", {16'd0, bus_a.popped_high, bus_a.popped_low}, 32'h9911);
        step_a(1'b1, POP, 8'h00, 1'b0);
        step_a(1'b1, POP, 8'h00, 1'b0);
        chk("c5_empty", 32'(bus_a.empty), 1);
        chk("c5_outs", {16'd0, bus_a.popped_high, bus_a.popped_low}, 0);
        chk("c5_hw", 32'(bus_a.high_water), 4);
        step_a(1'b0, PUSH, 8'hEE, 1'b0);
        chk("c5_disabled", 32'(bus_a.count), 0);
        step_a(1'b1, DUP, 8'h00, 1'b0);
        chk("c5_dup_empty", {30'd0, bus_a.overflow, bus_a.underflow}, 32'b01);
        chk("c5_dup_empty_cnt", 32'(bus_a.count), 0);

        // 6: asynchronous reset mid-cycle with a PUSH pending
        step_a(1'b1, PUSH, 8'hAA, 1'b0);
        chk("c6_pre_count", 32'(bus_a.count), 1);
        @(negedge clock);
        bus_a.stack_op = PUSH;
        bus_a.push_value = 8'hBB;
        bus_a.stack_enable = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("c6_async_count", 32'(bus_a.count), 0);
        chk("c6_async_flags", {30'd0, bus_a.overflow, bus_a.underflow}, 0);
        chk("c6_async_hw", 32'(bus_a.high_water), 0);
        chk("c6_async_high", 32'(bus_a.popped_high), 0);
        @(posedge clock);
        #1;
        chk("c6_held_count", 32'(bus_a.count), 0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("c6_first_count", 32'(bus_a.count), 1);
        chk("c6_first_high", 32'(bus_a.popped_high), 32'hBB);
        chk("c6_first_low", 32'(bus_a.popped_low), 0);
        chk("c6_first_hw", 32'(bus_a.high_water), 1);
        step_a(1'b0, NOP, 8'h00, 1'b0);

        // Wider, deeper instance
        for (int i = 1; i <= 3; i++) step_b(1'b1, PUSH, 12'hA00 + 12'(i));
        chk("b_count3", 32'(bus_b.count), 3);
        chk("b_high3", 32'(bus_b.popped_high), 32'hA03);
        chk("b_low3", 32'(bus_b.popped_low), 32'hA02);
        chk("b_hw3", 32'(bus_b.high_water), 3);
        for (int i = 4; i <= 8; i++) step_b(1'b1, PUSH, 12'hA00 + 12'(i));
        chk("b_full", 32'(bus_b.full), 1);
        chk("b_count8", 32'(bus_b.count), 8);
        chk("b_high8", 32'(bus_b.popped_high), 32'hA08);
        step_b(1'b1, PUSH, 12'hFFF);
        chk("b_ovf", 32'(bus_b.overflow), 1);
        chk("b_ovf_high", 32'(bus_b.popped_high), 32'hA08);
        step_b(1'b0, NOP, 12'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/param_stack.md
Name: param_stack

Overview:
- Next-generation hardware stack for the stack CPU: the data and call stacks both instantiate this block.
- Generalised data width and depth; adds DUP and SWAP operations.
- Adds full/empty status, overflow/underflow detection with sticky error flags, and a high-water-mark counter.
- Illegal operations are suppressed instead of silently wrapping the pointer.

Parameters:
WIDTH, 8, bits per stack entry
DEPTH, 16, number of entries (>=2)
CW, $clog2(DEPTH+1), width of occupancy count (derived, not overridden)

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
stack_enable  input  1  qualifies stack_op this cycle
stack_op  input  3  0 PUSH, 1 REPLACE, 2 POP2, 3 BINOP, 4 POP, 5 DUP, 6 SWAP, 7 NOP
push_value  input  WIDTH  data for PUSH / REPLACE / BINOP
err_clear  input  1  clears overflow/underflow sticky flags
popped_high  output  WIDTH  top entry (combinational)
popped_low  output  WIDTH  entry below top (combinational)
count  output  CW  current occupancy
full  output  1  count == DEPTH
empty  output  1  count == 0
overflow  output  1  sticky: suppressed op needed more space
underflow  output  1  sticky: suppressed op needed more entries
high_water  output  CW  maximum count reached since reset

Behaviour:
- Storage: entries mem[0..count-1]; the top is mem[count-1]. Memory contents are not reset.
- Reset (reset==0, asynchronous, takes effect immediately, including mid-operation):
  - count=0, overflow=0, underflow=0, high_water=0.
  - Hence empty=1, full=0, popped_high=0, popped_low=0.
  - Ops presented while reset is asserted are ignored.
- Operations take effect on the rising clock edge when stack_enable=1. With stack_enable=0 nothing changes. Let n = count before the edge.
  - PUSH: requires n<DEPTH. mem[n]<=push_value; count<=n+1.
  - REPLACE: requires n>=1. mem[n-1]<=push_value; count unchanged.
  - POP2: requires n>=2. count<=n-2.
  - BINOP (pop two, push ALU result): requires n>=2. mem[n-2]<=push_value; count<=n-1.
  - POP: requires n>=1. count<=n-1.
  - DUP: requires 1<=n<DEPTH. mem[n]<=mem[n-1]; count<=n+1.
  - SWAP: requires n>=2. mem[n-1] and mem[n-2] are exchanged in the same edge.
  - NOP: no effect, no error.
- Requirement violated:
  - The op is fully suppressed: no memory write, count unchanged.
  - Entry requirement violated -> underflow<=1. Space requirement violated -> overflow<=1.
  - DUP at n=0 sets underflow only (underflow takes priority).
- Flags:
  - Flags are sticky until err_clear=1 at a clock edge.
  - If err_clear and a new violation occur on the same edge, the flag ends set.
  - err_clear does not affect high_water.
- Read outputs (combinational from current state, valid in the same cycle):
  - popped_high = (count>=1) ? mem[count-1] : 0.
  - popped_low = (count>=2) ? mem[count-2] : 0.
- Latency: state updates on the edge; outputs reflect new state after that edge with no further delay.
- high_water <= max(high_water, new count) on every edge.
- Arithmetic: count never wraps. Values are stored unmodified at WIDTH bits.
- Write-read ordering: REPLACE or BINOP on the edge means popped_high after the edge shows the new value.

Test Plan:
1. WIDTH=8, DEPTH=4. Reset, then PUSH 0x11,0x22,0x33 -> count=3, popped_high=0x33, popped_low=0x22, high_water=3, empty=0, full=0.
2. From 1: PUSH 0x44 -> full=1. PUSH 0x55 -> overflow=1, count=4, popped_high=0x44. DUP -> overflow stays 1, state unchanged.
3. From 2: BINOP push_value=0x77 -> count=3, popped_high=0x77, popped_low=0x22. SWAP -> popped_high=0x22, popped_low=0x77. POP2 -> count=1, popped_high=0x11, popped_low=0.
4. Underflow: count=1, POP2 -> underflow=1, count=1. err_clear alone -> underflow=0. err_clear plus SWAP at count=1 on the same edge -> underflow=1.
5. DUP/REPLACE: count=1 top=0x11. DUP -> count=2, both outputs 0x11. REPLACE 0x99 -> popped_high=0x99, popped_low=0x11. POP, POP -> empty=1, outputs 0, high_water still 4.
6. Async reset: drive reset low mid-cycle while stack_enable=1 with PUSH -> count, flags and high_water go to 0 before the next edge; the first edge after reset is released starts from empty. Repeat case 1 with WIDTH=12, DEPTH=8 and fill to full=1 at count=8.
